// File: rtl/apb_master_bridge_pkg.sv
// rtl/apb_master_bridge_pkg.sv - shared APB widths, FSM encodings and timeout sizing helper
package apb_master_bridge_pkg;

  localparam int APB_ADDR_WIDTH   = 32;
  localparam int APB_DATA_WIDTH   = 32;
  localparam int APB_STROBE_WIDTH = APB_DATA_WIDTH / 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  // A disabled timeout (0 cycles) still needs a 1-bit counter to keep widths legal.
  function automatic int timeout_cnt_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/apb_timeout_counter.sv
// rtl/apb_timeout_counter.sv - saturating ACCESS-phase wait counter with limit detect
module apb_timeout_counter #(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] limit,
  output logic             expired
);

  logic [WIDTH-1:0] count;
  logic [WIDTH:0]   count_inc;

  assign count_inc = {1'b0, count} + {{WIDTH{1'b0}}, 1'b1};

  // Fires on the cycle whose increment would reach the limit, so the abort
  // lands exactly after `limit` waiting cycles; a zero limit never fires.
  assign expired = enable & (limit != '0) & (count_inc == {1'b0, limit});

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count_inc[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - single-outstanding APB4 requester with valid/ready command and response
module apb_master_bridge
  import apb_master_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                        pclk,
  input  logic                        preset,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_write,
  input  logic [APB_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [APB_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [APB_STROBE_WIDTH-1:0] cmd_strb,
  input  logic [2:0]                  cmd_prot,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [APB_DATA_WIDTH-1:0]   rsp_rdata,
  output logic                        rsp_slverr,
  output logic                        rsp_timeout,
  output logic [APB_ADDR_WIDTH-1:0]   paddr,
  output logic [APB_DATA_WIDTH-1:0]   pwdata,
  output logic [2:0]                  pprot,
  output logic                        pwrite,
  output logic [APB_STROBE_WIDTH-1:0] pstrb,
  output logic                        psel,
  output logic                        penable,
  input  logic                        pready,
  input  logic                        pslverr,
  input  logic [APB_DATA_WIDTH-1:0]   prdata
);

  localparam int               CNT_W         = timeout_cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TIMEOUT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [1:0] state;
  logic       tmo_expired;

  assign cmd_ready = (state == ST_IDLE) & ~rsp_valid & ~preset;

  apb_timeout_counter #(
    .WIDTH (CNT_W)
  ) u_timeout (
    .clk     (pclk),
    .rst     (preset),
    .clear   (state == ST_SETUP),
    .enable  ((state == ST_ACCESS) & ~pready),
    .limit   (TIMEOUT_LIMIT),
    .expired (tmo_expired)
  );

  always_ff @(posedge pclk) begin
    if (preset) begin
      state       <= ST_IDLE;
      psel        <= 1'b0;
      penable     <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      pstrb       <= '0;
      pprot       <= '0;
      pwrite      <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_slverr  <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            paddr   <= cmd_addr;
            pwrite  <= cmd_write;
            pprot   <= cmd_prot;
            // Reads never expose write data or strobes on the bus.
            pwdata  <= cmd_write ? cmd_wdata : '0;
            pstrb   <= cmd_write ? cmd_strb : '0;
            psel    <= 1'b1;
            penable <= 1'b0;
            state   <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          penable <= 1'b1;
          state   <= ST_ACCESS;
        end

        ST_ACCESS: begin
          // Completion is checked first so a late pready beats the timeout.
          if (pready) begin
            psel        <= 1'b0;
            penable     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_slverr  <= pslverr;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= pwrite ? '0 : prdata;
            state       <= ST_IDLE;
          end else if (tmo_expired) begin
            psel        <= 1'b0;
            penable     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_slverr  <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_rdata   <= '0;
            state       <= ST_IDLE;
          end
        end

        default: begin
          psel    <= 1'b0;
          penable <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
